// File: rtl/letc_core_fetch_pc_ctrl.sv
// Fetch PC sequencer for F1: owns the PC and picks hold / advance / branch / trap each cycle.
// Latency: pc updates at the next edge; o_lookup_pc_word and o_flush_f2 are same-cycle combinational.
// Backpressure: ~i_f2_ready / ~i_tlb_ready only hold pc; i_stall holds pc and parks redirects as pending.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_trap_req/i_trap_target     trap redirect pulse and handler PC word
//   i_branch_taken/_target       resolved taken branch pulse and target PC word
//   i_stall                      hazard stall, pc frozen while high
//   i_tlb_ready, i_f2_ready      ITLB translation valid / F2 accepts
//   o_pc_word                    registered fetch PC word
//   o_lookup_pc_word             PC word pc takes at the next edge (ITLB lookup)
//   o_fetch_valid                F1 output valid
//   o_flush_f2                   kill in-flight F1->F2 fetch, pulses when a redirect applies
//   o_redirect_pending           a captured redirect awaits stall release
module letc_core_fetch_pc_ctrl #(
   parameter int unsigned          PC_WORD_W         = 30,
   parameter logic [PC_WORD_W-1:0] RESET_PC_WORD     = '0,
   parameter int unsigned          RESET_HOLD_CYCLES = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_trap_req,
   input  logic [PC_WORD_W-1:0] i_trap_target,
   input  logic                 i_branch_taken,
   input  logic [PC_WORD_W-1:0] i_branch_target,
   input  logic                 i_stall,
   input  logic                 i_tlb_ready,
   input  logic                 i_f2_ready,
   output logic [PC_WORD_W-1:0] o_pc_word,
   output logic [PC_WORD_W-1:0] o_lookup_pc_word,
   output logic                 o_fetch_valid,
   output logic                 o_flush_f2,
   output logic                 o_redirect_pending
);

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_BUBBLE = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [3:0]             hold_cnt_q, hold_cnt_d;
   logic [PC_WORD_W-1:0]   pc_q, pc_d;
   logic                   pend_vld_q, pend_vld_d;
   logic [PC_WORD_W-1:0]   pend_pc_q, pend_pc_d;
   logic                   hold_done;
   logic                   may_apply;
   logic                   any_redirect;
   logic                   fire;
   logic [PC_WORD_W-1:0]   redirect_pc;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         pc_q       <= RESET_PC_WORD;
         pend_vld_q <= 1'b0;
         pend_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         pc_q       <= pc_d;
         pend_vld_q <= pend_vld_d;
         pend_pc_q  <= pend_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      pc_d          = pc_q;
      pend_vld_d    = pend_vld_q;
      pend_pc_d     = pend_pc_q;
      o_flush_f2    = 1'b0;
      o_fetch_valid = 1'b0;
      fire          = 1'b0;

      hold_done    = (state_q == ST_HOLD) && (hold_cnt_q == HOLD_LAST);
      // Redirects can only be taken when unstalled and out of the reset hold,
      // except on the final hold cycle where a parked redirect is consumed.
      may_apply    = ~i_rst & ~i_stall & ((state_q != ST_HOLD) | hold_done);
      any_redirect = i_trap_req | i_branch_taken | pend_vld_q;

      // New requests beat the parked one; trap beats branch.
      if (i_trap_req)          redirect_pc = i_trap_target;
      else if (i_branch_taken) redirect_pc = i_branch_target;
      else                     redirect_pc = pend_pc_q;

      o_fetch_valid = (state_q == ST_RUN) & i_tlb_ready & ~i_stall;
      fire          = o_fetch_valid & i_f2_ready;

      case (state_q)
         ST_HOLD: begin
            hold_cnt_d = hold_cnt_q + 4'd1;
            if (hold_done) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end
         end
         ST_BUBBLE: state_d = ST_RUN;
         default:   state_d = state_q;
      endcase

      if (may_apply && any_redirect) begin
         pc_d       = redirect_pc;
         o_flush_f2 = 1'b1;
         pend_vld_d = 1'b0;
         // One dead cycle lets the ITLB look up the new PC; the hold exit goes straight to RUN.
         if (state_q != ST_HOLD) state_d = ST_BUBBLE;
      end else begin
         if (fire) pc_d = pc_q + PC_WORD_W'(1);
         // A trap always replaces what is parked; a later branch is wrong-path
         // relative to anything already parked, so it only fills an empty slot.
         if (i_trap_req) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = i_trap_target;
         end else if (i_branch_taken && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = i_branch_target;
         end
      end
   end

   assign o_pc_word          = pc_q;
   assign o_lookup_pc_word   = pc_d;
   assign o_redirect_pending = pend_vld_q;

endmodule

// File: tb/tb_letc_core_fetch_pc_ctrl.sv
module tb_letc_core_fetch_pc_ctrl;

   localparam int          W      = 30;
   localparam int          H      = 4;
   localparam logic [29:0] RST_PC = 30'h0;

   logic          clk = 1'b0;
   logic          rst;
   logic          trap_req, branch_taken, stall, tlb_ready, f2_ready;
   logic [W-1:0]  trap_target, branch_target;
   logic [W-1:0]  pc_word, lookup_pc_word;
   logic          fetch_valid, flush_f2, redirect_pending;

   int checks = 0;
   int passes = 0;

   letc_core_fetch_pc_ctrl #(
      .PC_WORD_W(W), .RESET_PC_WORD(RST_PC), .RESET_HOLD_CYCLES(H)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_trap_req(trap_req), .i_trap_target(trap_target),
      .i_branch_taken(branch_taken), .i_branch_target(branch_target),
      .i_stall(stall), .i_tlb_ready(tlb_ready), .i_f2_ready(f2_ready),
      .o_pc_word(pc_word), .o_lookup_pc_word(lookup_pc_word),
      .o_fetch_valid(fetch_valid), .o_flush_f2(flush_f2),
      .o_redirect_pending(redirect_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural reference ----------------
   // Tracks cycles since reset release, whether the previous cycle applied a
   // redirect, and a one-deep queue of parked redirect targets.
   logic [29:0] m_pc;
   int          m_since;
   bit          m_bubble;
   logic [29:0] m_pend[$];
   bit          m_on = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_pc = RST_PC; m_since = 0; m_bubble = 1'b0; m_pend.delete();
            if (m_on) begin
               chk("m_rst_valid", 32'(fetch_valid), 32'd0);
               chk("m_rst_flush", 32'(flush_f2), 32'd0);
               chk("m_rst_pend", 32'(redirect_pending), 32'd0);
               chk("m_rst_pc", 32'(pc_word), 32'(RST_PC));
               chk("m_rst_lookup", 32'(lookup_pc_word), 32'(RST_PC));
            end
         end else begin
            bit          in_hold, last_hold, e_valid, e_fire, can_apply, have, e_flush;
            logic [29:0] tgt, e_next;
            in_hold   = (m_since < H);
            last_hold = (m_since == H - 1);
            e_valid   = !in_hold && !m_bubble && tlb_ready && !stall;
            e_fire    = e_valid && f2_ready;
            can_apply = !stall && (!in_hold || last_hold);
            have      = trap_req || branch_taken || (m_pend.size() > 0);
            if (trap_req)            tgt = trap_target;
            else if (branch_taken)   tgt = branch_target;
            else if (m_pend.size())  tgt = m_pend[0];
            else                     tgt = m_pc;

            chk("m_pc", 32'(pc_word), 32'(m_pc));
            chk("m_valid", 32'(fetch_valid), 32'(e_valid));
            chk("m_pend", 32'(redirect_pending), 32'(m_pend.size() > 0));

            if (can_apply && have) begin
               e_flush = 1'b1; e_next = tgt; m_pend.delete(); m_bubble = !in_hold;
            end else begin
               e_flush = 1'b0; e_next = e_fire ? m_pc + 30'd1 : m_pc; m_bubble = 1'b0;
               if (trap_req) begin
                  m_pend.delete(); m_pend.push_back(trap_target);
               end else if (branch_taken && m_pend.size() == 0) begin
                  m_pend.push_back(branch_target);
               end
            end
            chk("m_flush", 32'(flush_f2), 32'(e_flush));
            chk("m_lookup", 32'(lookup_pc_word), 32'(e_next));
            m_pc = e_next;
            if (m_since < H) m_since++;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; trap_req = 0; branch_taken = 0; stall = 0; tlb_ready = 1; f2_ready = 1;
      trap_target = '0; branch_target = '0;
      m_on = 1'b1;
      cyc(3);
      chk("rst_pc", 32'(pc_word), 32'h0);
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      chk("rst_lookup", 32'(lookup_pc_word), 32'h0);

      // Reset release: four dead cycles then sequential fetch from 0.
      rst = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", 32'(fetch_valid), 32'd0);
         cyc();
      end
      for (int i = 0; i < 4; i++) begin
         chk("seq_pc", 32'(pc_word), 32'(i));
         chk("seq_valid", 32'(fetch_valid), 32'd1);
         cyc();
      end

      // Branch redirect to 0x100.
      branch_taken = 1; branch_target = 30'h100; #1;
      chk("br_flush", 32'(flush_f2), 32'd1);
      chk("br_lookup", 32'(lookup_pc_word), 32'h100);
      cyc(); branch_taken = 0; #1;
      chk("br_bubble_pc", 32'(pc_word), 32'h100);
      chk("br_bubble_valid", 32'(fetch_valid), 32'd0);
      cyc();
      chk("br_fire0", 32'(pc_word), 32'h100);
      chk("br_fire0_valid", 32'(fetch_valid), 32'd1);
      cyc();
      chk("br_fire1", 32'(pc_word), 32'h101);
      cyc();

      // Sequential wrap at all-ones.
      branch_taken = 1; branch_target = 30'h3FFFFFFF; cyc(); branch_taken = 0;
      cyc();
      chk("wrap_pc", 32'(pc_word), 32'h3FFFFFFF);
      chk("wrap_lookup", 32'(lookup_pc_word), 32'h0);
      chk("wrap_flush", 32'(flush_f2), 32'd0);
      cyc();
      chk("wrap_pc0", 32'(pc_word), 32'h0);

      // Stalled: branch 0x200, branch 0x300, trap 0x40 -> trap wins after release.
      stall = 1; branch_taken = 1; branch_target = 30'h200; cyc();
      branch_target = 30'h300; cyc();
      branch_taken = 0; trap_req = 1; trap_target = 30'h40; cyc();
      trap_req = 0; #1;
      chk("stall_pend", 32'(redirect_pending), 32'd1);
      chk("stall_pc", 32'(pc_word), 32'h0);
      chk("stall_valid", 32'(fetch_valid), 32'd0);
      chk("stall_flush", 32'(flush_f2), 32'd0);
      cyc();
      stall = 0; #1;
      chk("rel_flush", 32'(flush_f2), 32'd1);
      chk("rel_lookup", 32'(lookup_pc_word), 32'h40);
      cyc();
      chk("rel_pc", 32'(pc_word), 32'h40);
      chk("rel_flush_once", 32'(flush_f2), 32'd0);
      chk("rel_pend", 32'(redirect_pending), 32'd0);
      cyc(2);

      // Trap + branch same cycle, then F2 backpressure.
      trap_req = 1; trap_target = 30'h40; branch_taken = 1; branch_target = 30'h80; #1;
      chk("tb_lookup", 32'(lookup_pc_word), 32'h40);
      cyc(); trap_req = 0; branch_taken = 0;
      cyc();
      chk("tb_pc", 32'(pc_word), 32'h40);
      f2_ready = 0; #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_pc", 32'(pc_word), 32'h40);
         chk("bp_lookup", 32'(lookup_pc_word), 32'(pc_word));
         cyc();
      end
      f2_ready = 1; cyc(2);

      // Reset in the middle of a stall with a parked redirect.
      stall = 1; branch_taken = 1; branch_target = 30'h500; cyc();
      branch_taken = 0; #1;
      chk("pre_rst_pend", 32'(redirect_pending), 32'd1);
      rst = 1; #1;
      chk("mid_rst_pc", 32'(pc_word), 32'(RST_PC));
      chk("mid_rst_pend", 32'(redirect_pending), 32'd0);
      chk("mid_rst_valid", 32'(fetch_valid), 32'd0);
      chk("mid_rst_flush", 32'(flush_f2), 32'd0);
      cyc(2);
      stall = 0; rst = 0; #1;
      for (int i = 0; i < 4; i++) begin
         chk("rehold_valid", 32'(fetch_valid), 32'd0);
         cyc();
      end
      chk("restart_pc", 32'(pc_word), 32'(RST_PC));
      chk("restart_valid", 32'(fetch_valid), 32'd1);
      cyc();
      chk("restart_pc1", 32'(pc_word), 32'(RST_PC + 30'd1));
      cyc(2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
